// File: rtl/rx_buffer_pkg.sv
// Shared widths and types for the receive buffer pool.
// Localparams describe the default geometry; the top derives its own widths from its parameters.
package rx_buffer_pkg;

  localparam int NUM_SLOTS_DFLT  = 16;
  localparam int FIFO_DEPTH_DFLT = 8;
  localparam int MAX_RGSTR_DFLT  = 7;

  localparam int SLOT_W = $clog2(NUM_SLOTS_DFLT);
  localparam int PTR_W  = SLOT_W + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH_DFLT) + 1;
  localparam int RNUM_W = $clog2(MAX_RGSTR_DFLT + 1);

  // Pool pointer: the wrap bit distinguishes full from empty when indices match.
  typedef struct packed {
    logic              wrap;
    logic [SLOT_W-1:0] index;
  } pool_ptr_t;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rx_slot_fifo.sv
// First-word-fall-through FIFO for one receive slot; head beat is visible on dout
// in the same cycle it is written into an empty FIFO's storage.
module rx_slot_fifo
  import rx_buffer_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = addr_bits(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop in the same cycle frees the space a push into a full FIFO needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rx_buffer_pool.sv
// Receive buffer pool: per-slot FIFOs fed by the push path, slot register/release
// accounting, and a rebasable Avalon-MM read map with one-cycle read latency.
module rx_buffer_pool
  import rx_buffer_pkg::*;
#(
  parameter int NUM_SLOTS  = NUM_SLOTS_DFLT,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT,
  parameter int ADDR_W     = 10,
  parameter int ADDR_LSB   = 3,
  parameter int MAX_RGSTR  = MAX_RGSTR_DFLT
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [ADDR_W-1:0]                  address,
  input  logic                               clken,
  input  logic                               chipselect,
  input  logic                               write,
  input  logic [DATA_W-1:0]                  writedata,
  input  logic [DATA_W/8-1:0]                byteenable,
  output logic [DATA_W-1:0]                  readdata,
  output logic                               readdatavalid,
  output logic                               waitrequest,
  input  logic [$clog2(NUM_SLOTS)-1:0]       pushQn,
  input  logic                               push,
  input  logic [DATA_W-1:0]                  pushData,
  input  logic                               bufRegister,
  input  logic [$clog2(MAX_RGSTR+1)-1:0]     rgstrNum,
  input  logic                               bufRelease,
  input  logic                               freshMapping,
  output logic [$clog2(NUM_SLOTS):0]         rgstrPtr,
  output logic [$clog2(NUM_SLOTS):0]         lastNum,
  output logic                               poolFull,
  output logic                               poolEmpty,
  output logic                               rgstrReject,
  output logic                               overrun,
  output logic                               underrun,
  input  logic                               errClear
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int PW = SW + 1;
  localparam int RW = $clog2(MAX_RGSTR + 1);
  localparam int CW = (RW > PW) ? RW : PW;

  typedef struct packed {
    logic          wrap;
    logic [SW-1:0] index;
  } ptr_t;

  ptr_t          reg_ptr;
  ptr_t          rel_ptr;
  logic [SW-1:0] base_ptr;
  logic [PW-1:0] last_num;

  logic          reg_ok;
  logic          rel_ok;
  logic [PW-1:0] reg_add;
  logic [PW-1:0] rel_add;

  logic [NUM_SLOTS-1:0] fifo_full;
  logic [NUM_SLOTS-1:0] fifo_empty;
  logic [NUM_SLOTS-1:0] fifo_push;
  logic [NUM_SLOTS-1:0] fifo_pop;
  logic [DATA_W-1:0]    fifo_dout [NUM_SLOTS];

  logic [SW-1:0] slot_field;
  logic [SW-1:0] real_slot;
  logic          rd_req;
  logic          rd_fire;
  logic          push_drop;
  logic          release_bad;
  logic          unused_avalon;

  // Writes are accepted and discarded; only the slot field of the address matters.
  assign unused_avalon = ^{address, writedata, byteenable};

  // ---------------- pool accounting ----------------
  assign poolEmpty = (reg_ptr == rel_ptr);
  assign poolFull  = (reg_ptr.index == rel_ptr.index) && (reg_ptr.wrap != rel_ptr.wrap);
  assign rgstrPtr  = reg_ptr;
  assign lastNum   = last_num;

  // Admission looks only at the current free count; a same-cycle release is not credited.
  assign reg_ok      = bufRegister && (rgstrNum != '0) && (CW'(rgstrNum) <= CW'(last_num));
  assign rel_ok      = bufRelease && !poolEmpty;
  assign release_bad = bufRelease && poolEmpty;
  assign reg_add     = reg_ok ? PW'(rgstrNum) : '0;
  assign rel_add     = {{(PW-1){1'b0}}, rel_ok};

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_ptr     <= '0;
      rel_ptr     <= '0;
      base_ptr    <= '0;
      last_num    <= PW'(NUM_SLOTS);
      rgstrReject <= 1'b0;
    end else begin
      reg_ptr     <= ptr_t'(reg_ptr + reg_add);
      rel_ptr     <= ptr_t'(rel_ptr + rel_add);
      last_num    <= last_num - reg_add + rel_add;
      rgstrReject <= bufRegister && !reg_ok;
      if (freshMapping) base_ptr <= rel_ptr.index;
    end
  end

  // ---------------- Avalon read map ----------------
  assign slot_field  = address[ADDR_LSB +: SW];
  assign real_slot   = base_ptr + slot_field;
  assign rd_req      = chipselect && clken && !write;
  assign waitrequest = rd_req && fifo_empty[real_slot];
  assign rd_fire     = rd_req && !fifo_empty[real_slot];

  always_comb begin
    fifo_pop            = '0;
    fifo_push           = '0;
    fifo_pop[real_slot] = rd_fire;
    fifo_push[pushQn]   = push;
  end

  assign push_drop = push && fifo_full[pushQn] && !fifo_pop[pushQn];

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      overrun       <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      readdatavalid <= rd_fire;
      if (rd_fire) readdata <= fifo_dout[real_slot];
      // A fresh error in the clearing cycle takes priority over the clear.
      if (push_drop)     overrun <= 1'b1;
      else if (errClear) overrun <= 1'b0;
      if (release_bad)   underrun <= 1'b1;
      else if (errClear) underrun <= 1'b0;
    end
  end

  // ---------------- slot FIFOs ----------------
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    rx_slot_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push[i]),
      .pop   (fifo_pop[i]),
      .din   (pushData),
      .dout  (fifo_dout[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );
  end

endmodule

// File: tb/tb_rx_buffer_pool.sv
// Randomised and directed bench for rx_buffer_pool with a queue-based reference
// model and a read-data scoreboard drained by an independent monitor.
module tb_rx_buffer_pool;

  localparam int NS    = 16;
  localparam int DW    = 256;
  localparam int DEPTH = 8;
  localparam int AW    = 10;
  localparam int LSB   = 3;
  localparam int SW    = 4;
  localparam int PW    = 5;
  localparam int RW    = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset;
  logic [AW-1:0]   address;
  logic            clken;
  logic            chipselect;
  logic            write;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;
  logic            waitrequest;
  logic [SW-1:0]   pushQn;
  logic            push;
  logic [DW-1:0]   pushData;
  logic            bufRegister;
  logic [RW-1:0]   rgstrNum;
  logic            bufRelease;
  logic            freshMapping;
  logic [PW-1:0]   rgstrPtr;
  logic [PW-1:0]   lastNum;
  logic            poolFull;
  logic            poolEmpty;
  logic            rgstrReject;
  logic            overrun;
  logic            underrun;
  logic            errClear;

  rx_buffer_pool dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .clken         (clken),
    .chipselect    (chipselect),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .pushQn        (pushQn),
    .push          (push),
    .pushData      (pushData),
    .bufRegister   (bufRegister),
    .rgstrNum      (rgstrNum),
    .bufRelease    (bufRelease),
    .freshMapping  (freshMapping),
    .rgstrPtr      (rgstrPtr),
    .lastNum       (lastNum),
    .poolFull      (poolFull),
    .poolEmpty     (poolEmpty),
    .rgstrReject   (rgstrReject),
    .overrun       (overrun),
    .underrun      (underrun),
    .errClear      (errClear)
  );

  // ---------------- scoreboard and reference model ----------------
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  logic [DW-1:0] m_q [NS][$];
  int m_reg, m_rel, m_base, m_last;
  bit m_over, m_under, m_rej;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int outstanding();
    return (m_reg - m_rel + 2 * NS) % (2 * NS);
  endfunction

  task automatic model_reset();
    m_reg = 0; m_rel = 0; m_base = 0; m_last = NS;
    m_over = 0; m_under = 0; m_rej = 0;
    for (int i = 0; i < NS; i++) m_q[i].delete();
  endtask

  task automatic check_state();
    check("rgstr_ptr", rgstrPtr, m_reg);
    check("last_num", lastNum, m_last);
    check("last_vs_outstanding", lastNum, NS - outstanding());
    check("pool_empty", poolEmpty, outstanding() == 0);
    check("pool_full", poolFull, outstanding() == NS);
    check("rgstr_reject", rgstrReject, m_rej);
    check("overrun", overrun, m_over);
    check("underrun", underrun, m_under);
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    reset = 0; address = '0; clken = 1; chipselect = 0; write = 0;
    writedata = '0; byteenable = '0; pushQn = '0; push = 0; pushData = '0;
    bufRegister = 0; rgstrNum = '0; bufRelease = 0; freshMapping = 0; errClear = 0;
  endtask

  // Called at a falling edge with inputs set; applies one rising edge.
  task automatic step();
    int rs;
    bit rd, pop, space, reg_ok, rel_ok;
    if (reset) begin
      @(posedge clock); #1;
      model_reset();
      check_state();
      check("reset_readdata", readdata, '0);
      check("reset_valid", readdatavalid, 1'b0);
      @(negedge clock);
      idle();
      return;
    end
    rd = chipselect && clken && !write;
    rs = (m_base + int'(address[LSB +: SW])) % NS;
    #1;
    check("waitrequest", waitrequest, rd && (m_q[rs].size() == 0));
    pop = rd && (m_q[rs].size() != 0);
    if (pop) exp_q.push_back(m_q[rs][0]);
    space  = push && ((m_q[pushQn].size() < DEPTH) || (pop && rs == int'(pushQn)));
    reg_ok = bufRegister && (rgstrNum != 0) && (int'(rgstrNum) <= m_last);
    rel_ok = bufRelease && (outstanding() != 0);
    @(posedge clock); #1;
    if (pop) void'(m_q[rs].pop_front());
    if (space) m_q[pushQn].push_back(pushData);
    m_over  = (push && !space) ? 1'b1 : (errClear ? 1'b0 : m_over);
    m_under = (bufRelease && !rel_ok) ? 1'b1 : (errClear ? 1'b0 : m_under);
    m_rej   = bufRegister && !reg_ok;
    if (freshMapping) m_base = m_rel % NS;
    if (reg_ok) begin
      m_reg  = (m_reg + int'(rgstrNum)) % (2 * NS);
      m_last = m_last - int'(rgstrNum);
    end
    if (rel_ok) begin
      m_rel  = (m_rel + 1) % (2 * NS);
      m_last = m_last + 1;
    end
    check_state();
    @(negedge clock);
    idle();
  endtask

  task automatic do_reset();
    check("drain_before_reset", exp_q.size(), 0);
    exp_q.delete();
    reset = 1;
    step();
  endtask

  task automatic do_reg(input int n);
    bufRegister = 1; rgstrNum = RW'(n); step();
  endtask

  task automatic do_rel();
    bufRelease = 1; step();
  endtask

  task automatic do_push(input int slot, input logic [DW-1:0] d);
    push = 1; pushQn = SW'(slot); pushData = d; step();
  endtask

  task automatic set_read(input int field);
    chipselect = 1; clken = 1; write = 0;
    address = AW'(field << LSB);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clock) begin
    #2;
    if (readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_valid", readdatavalid, 1'b0);
      else check("readdata", readdata, exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    @(negedge clock);
    do_reset();

    // register accounting up to full, then a refused request
    do_reg(5); do_reg(3);
    check("reg8_ptr", rgstrPtr, 8);
    check("reg8_last", lastNum, 8);
    check("reg8_empty", poolEmpty, 1'b0);
    do_reg(7); do_reg(1);
    check("full_last", lastNum, 0);
    check("full_flag", poolFull, 1'b1);
    do_reg(1);
    check("reject_pulse", rgstrReject, 1'b1);
    check("reject_ptr", rgstrPtr, 16);

    // full release cycle, wrap, and underrun
    do_reset();
    do_reg(7); do_reg(7); do_reg(2);
    for (int i = 0; i < 16; i++) do_rel();
    do_rel();
    check("wrap_ptr", rgstrPtr, 16);
    check("wrap_empty", poolEmpty, 1'b1);
    check("underrun_set", underrun, 1'b1);
    errClear = 1; step();
    check("underrun_clear", underrun, 1'b0);

    // in-order reads from slot 3, then a stalled read
    do_reset();
    for (int i = 0; i < 4; i++) do_push(3, DW'(32'hA + i));
    for (int i = 0; i < 4; i++) begin set_read(3); step(); end
    set_read(3); #1;
    check("stall_wait", waitrequest, 1'b1);
    step();

    // rebased map: base 14 + field 3 selects slot 1
    do_reset();
    do_reg(7); do_reg(7);
    for (int i = 0; i < 14; i++) do_rel();
    freshMapping = 1; step();
    do_push(1, DW'(32'h55));
    set_read(3); step();

    // overrun on slot 0, then push and pop together while full
    do_reset();
    for (int i = 0; i < 9; i++) do_push(0, rand_beat());
    check("overrun_set", overrun, 1'b1);
    set_read(0); push = 1; pushQn = '0; pushData = rand_beat(); step();
    check("full_pushpop_no_overrun", overrun, 1'b1);
    for (int i = 0; i < 8; i++) begin set_read(0); step(); end
    set_read(0); #1;
    check("occupancy_8_stall", waitrequest, 1'b1);
    step();

    // simultaneous register and release
    do_reset();
    do_reg(6);
    check("last_10", lastNum, 10);
    bufRegister = 1; rgstrNum = 3'd2; bufRelease = 1; step();
    check("last_9", lastNum, 9);

    // reset during an accepted read drops the data and the valid
    do_reset();
    do_push(2, rand_beat());
    set_read(2); reset = 1; step();
    set_read(2); #1;
    check("after_reset_stall", waitrequest, 1'b1);
    step();

    // randomised traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      push         = ($urandom_range(0, 1) == 1);
      pushQn       = SW'($urandom_range(0, NS - 1));
      pushData     = rand_beat();
      chipselect   = ($urandom_range(0, 3) != 0);
      clken        = ($urandom_range(0, 7) != 0);
      write        = ($urandom_range(0, 5) == 0);
      writedata    = rand_beat();
      byteenable   = '1;
      address      = AW'($urandom);
      bufRegister  = ($urandom_range(0, 4) == 0);
      rgstrNum     = RW'($urandom_range(0, 7));
      bufRelease   = ($urandom_range(0, 2) == 0);
      freshMapping = ($urandom_range(0, 15) == 0);
      errClear     = ($urandom_range(0, 9) == 0);
      step();
    end

    repeat (3) @(negedge clock);
    check("final_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_buffer_pool.md
Name: rx_buffer_pool

Overview:
Parametrised receive-side buffer between the RDMA push path and the PCIe Avalon-MM read slave. NUM_SLOTS per-queue data FIFOs hold inbound beats. A slot pool with register/release pointers and a free counter allocates slots to outstanding requests. A rebasable address map turns host read addresses into slot indices. Compared with the previous generation it adds generic width, depth and slot count, guarded registration with reject, readdatavalid signalling, and sticky error reporting.

Parameters:
NUM_SLOTS, 16, slot/FIFO count; power of 2, 2..64
DATA_W, 256, beat width in bits; multiple of 8
FIFO_DEPTH, 8, beats per slot FIFO; power of 2
ADDR_W, 10, Avalon word-address width
ADDR_LSB, 3, lowest address bit of the slot-index field; address[ADDR_LSB +: SLOT_W] selects the slot
MAX_RGSTR, 7, largest rgstrNum value

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
address  in  ADDR_W  Avalon word address
clken  in  1  slave clock enable; gates all Avalon activity
chipselect  in  1  slave select
write  in  1  1 = write, 0 = read
writedata  in  DATA_W  accepted and discarded
byteenable  in  DATA_W/8  ignored
readdata  out  DATA_W  registered read data
readdatavalid  out  1  one-cycle strobe qualifying readdata
waitrequest  out  1  read stall
pushQn  in  SLOT_W  target slot for push (SLOT_W = clog2(NUM_SLOTS))
push  in  1  push strobe
pushData  in  DATA_W  push beat
bufRegister  in  1  allocate rgstrNum slots
rgstrNum  in  clog2(MAX_RGSTR+1)  number of slots requested
bufRelease  in  1  free one slot
freshMapping  in  1  rebase the read map
rgstrPtr  out  SLOT_W+1  register pointer
lastNum  out  SLOT_W+1  free slot count
poolFull  out  1  all slots registered
poolEmpty  out  1  no slots registered
rgstrReject  out  1  registered pulse: request refused
overrun  out  1  sticky: push dropped
underrun  out  1  sticky: illegal release
errClear  in  1  clears overrun and underrun

Behaviour:
- Reset (synchronous, active-high) applies on the clock edge and overrides every same-cycle event. Results: regPtr = relPtr = basePtr = 0; lastNum = NUM_SLOTS; all FIFOs empty; readdata = 0; readdatavalid, rgstrReject, overrun and underrun all 0. Reset mid-transfer discards all data and drops any pending readdatavalid.
- Pointers are SLOT_W+1 bits wide and wrap modulo 2*NUM_SLOTS.
- poolEmpty = (regPtr == relPtr).
- poolFull = low SLOT_W bits equal and MSBs differ.
- Register: when bufRegister=1, rgstrNum <= lastNum and rgstrNum != 0, then regPtr += rgstrNum and lastNum -= rgstrNum. Otherwise the request is refused: rgstrReject=1 on the next cycle and no state changes. The check uses the current lastNum only; a same-cycle release is not credited.
- Release: when bufRelease=1 and !poolEmpty, then relPtr += 1 and lastNum += 1. A release while empty is ignored and sets underrun.
- Simultaneous accepted register and release: lastNum_next = lastNum - rgstrNum + 1; both pointers advance.
- Map: when freshMapping=1, basePtr <= relPtr[SLOT_W-1:0] (pre-update value).
- realSlot = (basePtr + address[ADDR_LSB +: SLOT_W]) mod NUM_SLOTS. The address field is exactly SLOT_W bits.
- Read request: chipselect & clken & !write.
- waitrequest = read request & empty[realSlot], combinational. While stalled there is no pop and no readdatavalid.
- Non-stalled read: pop realSlot; readdata <= head beat; readdatavalid=1 on the next cycle. Fixed latency is 1. readdata holds its value otherwise.
- Write: waitrequest=0; no state change.
- Push: beat enters slot pushQn if that slot is not full. A push to a full slot is dropped and sets overrun.
- Push and pop on the same slot in the same cycle both succeed, including when the slot is full (the pop frees space first) and when it is empty with depth 0 (the push lands, the pop stalls).
- errClear clears the sticky bits. A new error in the same cycle wins over the clear.
- FIFOs are first-word-fall-through with 0-cycle head visibility. Occupancy counter width is clog2(FIFO_DEPTH)+1.

Decomposition:
- Package rx_buffer_pkg: clog2-derived width localparams (SLOT_W, PTR_W, CNT_W, RNUM_W) and the pool-pointer struct typedef {wrap bit, index}.
- Sub-module rx_slot_fifo: DATA_W x FIFO_DEPTH FWFT FIFO with push, pop, dout, full, empty. It is instantiated NUM_SLOTS times in a generate loop.
- Pool accounting, map and Avalon read logic stay in the top level.

Test Plan:
- Reset, then bufRegister with rgstrNum=5, then 3 -> regPtr=8, lastNum=8, poolEmpty=0. A further rgstrNum=7 and then 1 -> lastNum=0, poolFull=1. One more rgstrNum=1 -> rgstrReject pulse, no change.
- Register 16, release 16 times, then release once more -> relPtr=16 (wrap bit set), poolEmpty=1, underrun=1. errClear -> underrun=0.
- Push 0xA..0xD to slot 3, read address 3<<ADDR_LSB four times -> readdatavalid one cycle after each accept, data 0xA,0xB,0xC,0xD in order. Fifth read -> waitrequest=1, no valid.
- Register 14, release 14, freshMapping=1 (basePtr=14), push 0x55 into slot 1, read with address field=3 -> realSlot=1, readdata=0x55.
- Push 9 beats to slot 0 (depth 8) -> 9th beat dropped, overrun=1. Same-cycle push and read on slot 0 while full -> both succeed, occupancy stays 8.
- Same-cycle bufRegister(rgstrNum=2) and bufRelease with lastNum=10 -> lastNum=9.
